// File: rtl/iic_op_engine_if.sv
// Op-FIFO pop, rx-FIFO push, status and open-drain pad bundle between the engine and its surroundings.
interface iic_op_engine_if;
    logic        op_fifo_rd_en;
    logic [11:0] op_fifo_rd_data;
    logic        op_fifo_empty;
    logic        op_fifo_block;
    logic        rx_fifo_wr_en;
    logic [7:0]  rx_fifo_wr_data;
    logic        op_error;
    logic        busy;
    logic        scl_i;
    logic        sda_i;
    logic        scl_oen;
    logic        sda_oen;

    modport master (
        output op_fifo_rd_en,
        input  op_fifo_rd_data, op_fifo_empty, op_fifo_block,
        output rx_fifo_wr_en, rx_fifo_wr_data, op_error, busy,
        input  scl_i, sda_i,
        output scl_oen, sda_oen
    );

    modport slave (
        input  op_fifo_rd_en,
        output op_fifo_rd_data, op_fifo_empty, op_fifo_block,
        input  rx_fifo_wr_en, rx_fifo_wr_data, op_error, busy,
        output scl_i, sda_i,
        input  scl_oen, sda_oen
    );
endinterface

// File: rtl/iic_op_engine.sv
// IIC master bit engine: one op word per START/byte/ACK/STOP run, 2 + 4*CLK_DIV per phase clocks; stalls on empty/blocked op FIFO.
// Define IIC_CLOCK_STRETCH_EN to let a slave holding SCL low freeze the quarter counter.
module iic_op_engine #(
    parameter int CLK_DIV = 250,
    parameter int DIV_W   = 16
) (
    input  logic            OPB_Clk,
    input  logic            OPB_Rst_n,
    iic_op_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, BIT, ACK, STOP} state_t;
    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(CLK_DIV - 1);

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [1:0]       q;
    logic [2:0]       idx;
    logic [10:0]      op;
    logic [7:0]       shreg;
    logic             sda_smp;
    logic             tick;
    logic             stall;
    logic             timed;

    // Read bits release SDA; write bits drive the data bit.
    function automatic logic bit_sda(input logic [10:0] w, input logic [2:0] i);
        return w[9] | w[i];
    endfunction

`ifdef IIC_CLOCK_STRETCH_EN
    assign stall = bus.scl_oen && !bus.scl_i;
`else
    assign stall = 1'b0;
`endif
    assign tick  = (cnt == CNT_MAX);
    assign timed = (state inside {START, BIT, ACK, STOP});

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            q                   <= '0;
            idx                 <= '0;
            op                  <= '0;
            shreg               <= '0;
            sda_smp             <= 1'b1;
            bus.op_fifo_rd_en   <= 1'b0;
            bus.rx_fifo_wr_en   <= 1'b0;
            bus.rx_fifo_wr_data <= '0;
            bus.op_error        <= 1'b0;
            bus.busy            <= 1'b0;
            bus.scl_oen         <= 1'b1;
            bus.sda_oen         <= 1'b1;
        end else begin
            bus.op_fifo_rd_en <= 1'b0;
            bus.rx_fifo_wr_en <= 1'b0;
            bus.op_error      <= 1'b0;
            if (timed) begin
                cnt <= (stall || tick) ? '0 : cnt + DIV_W'(1);
                if (tick) q <= q + 2'd1;
            end
            // Line values are registered on entry to each quarter.
            unique case (state)
                IDLE: if (!bus.op_fifo_empty && !bus.op_fifo_block) begin
                    bus.op_fifo_rd_en <= 1'b1;
                    bus.busy          <= 1'b1;
                    state             <= FETCH;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    op  <= bus.op_fifo_rd_data[10:0];
                    cnt <= '0;
                    q   <= '0;
                    if (bus.op_fifo_rd_data[11]) begin
                        state       <= START;
                        bus.sda_oen <= 1'b1;
                    end else begin
                        state       <= BIT;
                        idx         <= 3'd7;
                        bus.scl_oen <= 1'b0;
                        bus.sda_oen <= bit_sda(bus.op_fifo_rd_data[10:0], 3'd7);
                    end
                end
                START: if (tick) begin
                    unique case (q)
                        2'd0: bus.scl_oen <= 1'b1;
                        2'd1: bus.sda_oen <= 1'b0;
                        2'd2: bus.scl_oen <= 1'b0;
                        2'd3: begin
                            state       <= BIT;
                            idx         <= 3'd7;
                            bus.sda_oen <= bit_sda(op, 3'd7);
                        end
                    endcase
                end
                BIT: if (tick) begin
                    unique case (q)
                        2'd0: ;
                        2'd1: bus.scl_oen <= 1'b1;
                        2'd2: shreg <= {shreg[6:0], bus.sda_i};
                        2'd3: begin
                            bus.scl_oen <= 1'b0;
                            if (idx == 3'd0) begin
                                state       <= ACK;
                                bus.sda_oen <= !op[9] | op[8];
                            end else begin
                                idx         <= idx - 3'd1;
                                bus.sda_oen <= bit_sda(op, idx - 3'd1);
                            end
                        end
                    endcase
                end
                ACK: if (tick) begin
                    unique case (q)
                        2'd0: ;
                        2'd1: bus.scl_oen <= 1'b1;
                        2'd2: sda_smp <= bus.sda_i;
                        2'd3: begin
                            if (op[9]) begin
                                bus.rx_fifo_wr_en   <= 1'b1;
                                bus.rx_fifo_wr_data <= shreg;
                            end else if (sda_smp) begin
                                bus.op_error <= 1'b1;
                            end
                            // Without STOP, SCL stays low so the next op owns the bus.
                            bus.scl_oen <= 1'b0;
                            if (op[10]) begin
                                state       <= STOP;
                                bus.sda_oen <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end
                    endcase
                end
                STOP: if (tick) begin
                    unique case (q)
                        2'd0: bus.scl_oen <= 1'b1;
                        2'd1: bus.sda_oen <= 1'b1;
                        2'd2: ;
                        2'd3: begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iic_op_engine.sv
`timescale 1ns/1ps
module tb_iic_op_engine;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iic_op_engine_if bus();
    iic_op_engine #(.CLK_DIV(CLK_DIV), .DIV_W(16)) dut (
        .OPB_Clk   (clk),
        .OPB_Rst_n (rst_n),
        .bus       (bus)
    );

    // Op FIFO model: one-cycle read latency after the pop strobe.
    logic [11:0] op_mem [0:31];
    int          op_wr = 0;
    int          op_rd = 0;
    logic [11:0] op_dat = '0;
    always @(posedge clk) begin
        if (bus.op_fifo_rd_en) begin
            op_dat <= op_mem[op_rd % 32];
            op_rd  <= op_rd + 1;
        end
    end
    assign bus.op_fifo_rd_data = op_dat;
    assign bus.op_fifo_empty   = (op_rd == op_wr);

    // Open-drain bus with a slave that may stretch SCL and pull SDA.
    logic block   = 1'b0;
    logic stretch = 1'b0;
    logic s_sda   = 1'b1;
    logic scl_line, sda_line;
    assign scl_line          = bus.scl_oen & ~stretch;
    assign sda_line          = bus.sda_oen & s_sda;
    assign bus.scl_i         = scl_line;
    assign bus.sda_i         = sda_line;
    assign bus.op_fifo_block = block;

    logic       sbits[$];
    logic [8:0] exp_frames[$];
    logic [7:0] exp_rx[$];
    logic [11:0] exp_err[$];
    int tests  = 0;
    int fails  = 0;
    int n_pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_op(input logic [11:0] w);
        op_mem[op_wr % 32] = w;
        op_wr++;
    endtask

    task automatic slave_write(input logic ack_bit);
        for (int i = 0; i < 8; i++) sbits.push_back(1'b1);
        sbits.push_back(ack_bit);
    endtask

    task automatic slave_read(input logic [7:0] b);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) sbits.push_back(v[i]);
        sbits.push_back(1'b1);
    endtask

    // Bus monitor acting as slave: a bit commits on the SCL fall unless SDA moved while SCL was high.
    task automatic monitor();
        logic pscl = 1'b1, psda = 1'b1, pbusy = 1'b0, prx = 1'b0, perr = 1'b0;
        logic tent = 1'b0, tbit = 1'b1;
        logic [8:0] sh = '0;
        int nb = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sbits.delete();
                tent  = 1'b0;
                nb    = 0;
                s_sda = 1'b1;
            end else begin
                if (scl_line && !pscl) begin
                    tent = 1'b1;
                    tbit = sda_line;
                end else if (scl_line && pscl && sda_line !== psda) begin
                    tent = 1'b0;
                end else if (!scl_line && pscl && tent) begin
                    tent = 1'b0;
                    sh   = {sh[7:0], tbit};
                    nb++;
                    if (sbits.size() > 0) void'(sbits.pop_front());
                    if (nb == 9) begin
                        nb = 0;
                        if (exp_frames.size() == 0) check("bus_frame_unexpected", 32'(sh), 32'hFFFF_FFFF);
                        else check("bus_frame", 32'(sh), 32'(exp_frames.pop_front()));
                    end
                end
                s_sda = (sbits.size() > 0) ? sbits[0] : 1'b1;
                if (bus.rx_fifo_wr_en) begin
                    check("rx_pulse_width", 32'(prx), 32'd0);
                    if (exp_rx.size() == 0) check("rx_unexpected", 32'(bus.rx_fifo_wr_data), 32'hFFFF_FFFF);
                    else check("rx_data", 32'(bus.rx_fifo_wr_data), 32'(exp_rx.pop_front()));
                end
                if (bus.op_error) begin
                    check("err_pulse_width", 32'(perr), 32'd0);
                    if (exp_err.size() == 0) check("op_error_unexpected", 32'(bus.op_error), 32'd0);
                    else void'(exp_err.pop_front());
                end
                if (bus.op_fifo_rd_en) begin
                    n_pops++;
                    check("pop_while_busy", 32'(pbusy), 32'd0);
                    check("pop_while_blocked", 32'(block), 32'd0);
                end
            end
            pscl  = scl_line;
            psda  = sda_line;
            pbusy = bus.busy;
            prx   = bus.rx_fifo_wr_en;
            perr  = bus.op_error;
        end
    endtask

    task automatic wait_all(input int budget, output int busy_cycles);
        int n;
        n = 0;
        busy_cycles = 0;
        @(negedge clk);
        while (!(bus.op_fifo_empty && !bus.busy)) begin
            if (bus.busy) busy_cycles++;
            n++;
            if (n > budget) begin
                tests++;
                fails++;
                $display("FAIL wait_all: timeout after %0d cycles", budget);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
        check(name, 32'(bus.busy), 32'd1);
    endtask

    initial begin
        int bc;
        int pre;
        fork
            monitor();
        join_none

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en",   32'(bus.op_fifo_rd_en),   32'd0);
        check("rst_wr_en",   32'(bus.rx_fifo_wr_en),   32'd0);
        check("rst_wr_data", 32'(bus.rx_fifo_wr_data), 32'd0);
        check("rst_op_error",32'(bus.op_error),        32'd0);
        check("rst_busy",    32'(bus.busy),            32'd0);
        check("rst_scl_oen", 32'(bus.scl_oen),         32'd1);
        check("rst_sda_oen", 32'(bus.sda_oen),         32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_pop", 32'(n_pops), 32'd0);

        // START + write 0x5A + ACK + STOP
        slave_write(1'b0);
        exp_frames.push_back({8'h5A, 1'b0});
        push_op(12'hC5A);
        wait_all(2000, bc);
        check("t1_busy_cycles", 32'(bc), 32'd178);
        check("t1_scl_released", 32'(bus.scl_oen), 32'd1);
        check("t1_sda_released", 32'(bus.sda_oen), 32'd1);

        // Slave NACK on write, no STOP
        slave_write(1'b1);
        exp_frames.push_back({8'hA0, 1'b1});
        exp_err.push_back(12'h8A0);
        push_op(12'h8A0);
        wait_all(2000, bc);
        check("t2_error_seen", 32'(exp_err.size()), 32'd0);
        check("t2_scl_held_low", 32'(bus.scl_oen), 32'd0);
        repeat (10) @(negedge clk);
        check("t2_scl_still_low", 32'(scl_line), 32'd0);

        // Repeated START write, then read with master NACK and STOP
        slave_write(1'b0);
        slave_read(8'hC3);
        exp_frames.push_back({8'hA1, 1'b0});
        exp_frames.push_back({8'hC3, 1'b1});
        exp_rx.push_back(8'hC3);
        push_op(12'h8A1);
        push_op(12'h700);
        wait_all(4000, bc);
        check("t3_rx_seen", 32'(exp_rx.size()), 32'd0);
        check("t3_scl_released", 32'(scl_line), 32'd1);
        check("t3_sda_released", 32'(sda_line), 32'd1);

        // Blocked fetch, then release
        block = 1'b1;
        pre = n_pops;
        for (int i = 0; i < 3; i++) slave_write(1'b0);
        exp_frames.push_back({8'h11, 1'b0});
        exp_frames.push_back({8'h22, 1'b0});
        exp_frames.push_back({8'h33, 1'b0});
        push_op(12'h811);
        push_op(12'h022);
        push_op(12'h433);
        repeat (50) @(negedge clk);
        check("t4_blocked_pops", 32'(n_pops - pre), 32'd0);
        check("t4_blocked_busy", 32'(bus.busy), 32'd0);
        block = 1'b0;
        wait_all(6000, bc);
        check("t4_pops", 32'(n_pops - pre), 32'd3);
        check("t4_scl_released", 32'(scl_line), 32'd1);

        // Reset in the middle of bit index 4, then the next queued op runs
        pre = n_pops;
        push_op(12'hC77);
        push_op(12'hC12);
        wait_busy("t5_started");
        repeat (74) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_scl_oen", 32'(bus.scl_oen), 32'd1);
        check("t5_sda_oen", 32'(bus.sda_oen), 32'd1);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_strobes", 32'({bus.op_fifo_rd_en, bus.rx_fifo_wr_en, bus.op_error}), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_held_pops", 32'(n_pops - pre), 32'd1);
        rst_n = 1'b1;
        slave_write(1'b0);
        exp_frames.push_back({8'h12, 1'b0});
        wait_all(2000, bc);
        check("t5_resume_busy", 32'(bc), 32'd178);
        check("t5_pops", 32'(n_pops - pre), 32'd2);

`ifdef IIC_CLOCK_STRETCH_EN
        // Slave holds SCL low for 20 clocks after the release in bit 7
        slave_write(1'b0);
        exp_frames.push_back({8'h5A, 1'b0});
        push_op(12'hC5A);
        wait_busy("t6_started");
        repeat (25) @(negedge clk);
        stretch = 1'b1;
        repeat (21) @(negedge clk);
        stretch = 1'b0;
        wait_all(2000, bc);
        check("t6_stretched_busy", 32'(bc + 47), 32'd198);
`endif

        repeat (5) @(negedge clk);
        check("frames_left", 32'(exp_frames.size()), 32'd0);
        check("rx_left", 32'(exp_rx.size()), 32'd0);
        check("err_left", 32'(exp_err.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iic_op_engine.md
Name: iic_op_engine

Overview:
- IIC master bit engine directly downstream of the OPB IIC attach block.
- Pops 12-bit operation words from the op FIFO and executes START/byte/STOP sequences on open-drain SCL/SDA.
- Pushes received bytes into the rx FIFO and pulses op_error on a slave NACK.

Parameters:
- CLK_DIV, 250, clocks per quarter SCL bit; SCL frequency = clk / (4*CLK_DIV); legal range 2..65535.
- DIV_W, 16, width of the quarter-phase counter; must hold CLK_DIV-1.

Ports:
- OPB_Clk  in  1  system clock; all logic on rising edge
- OPB_Rst_n  in  1  reset, synchronous, active-low
- op_fifo_rd_en  out  1  single-cycle pop strobe; data valid the cycle after
- op_fifo_rd_data  in  12  op word: [11]=START, [10]=STOP, [9]=RNW, [8]=master NACK on read, [7:0]=write data
- op_fifo_empty  in  1  op FIFO empty
- op_fifo_block  in  1  inhibit fetching of new ops
- rx_fifo_wr_en  out  1  single-cycle push strobe
- rx_fifo_wr_data  out  8  received byte
- op_error  out  1  single-cycle pulse on slave NACK during write
- busy  out  1  high whenever state != IDLE
- scl_i, sda_i  in  1 each  pad inputs
- scl_oen, sda_oen  out  1 each  1 = release line (pulled high), 0 = drive low

Behaviour:
- Reset values: op_fifo_rd_en=0, rx_fifo_wr_en=0, rx_fifo_wr_data=0, op_error=0, busy=0, scl_oen=1, sda_oen=1. Reset mid-operation aborts at once to IDLE, releases both lines, and issues no strobes.
- Quarter tick: counter runs 0..CLK_DIV-1 while in a timed state; tick = (count==CLK_DIV-1); a 2-bit phase q advances on each tick. Counter and q clear on entry to every timed state.
- States: IDLE, FETCH, LOAD, START, BIT, ACK, STOP.
- IDLE: if !op_fifo_empty && !op_fifo_block, assert op_fifo_rd_en for 1 cycle and go to FETCH. The pop occurs 0 cycles after the condition is seen.
- FETCH: 1-cycle wait for FIFO read latency. LOAD: capture the op word, then go to START if [11], else BIT.
- START, q0..q3: SDA rel, SCL unchanged / SDA rel, SCL rel / SDA low, SCL rel / SDA low, SCL low. The same sequence serves as a repeated START. Then go to BIT with bit index 7.
- BIT, per bit, q0..q3: SCL low with SDA set (write: data[idx]; read: released) / SCL low / SCL rel / SCL rel.
  - sda_i is sampled on the q2 to q3 tick.
  - Read bits shift MSB first.
  - After idx 0, go to ACK.
- ACK: same 4-quarter timing.
  - Write: SDA released; sampled sda_i=1 gives op_error=1 for exactly 1 cycle at the end of ACK.
  - Read: SDA = op[8] (1 = release/NACK, 0 = drive low); at the end of ACK, rx_fifo_wr_en=1 for 1 cycle with the assembled byte.
  - rx_fifo_full is not checked; the write still occurs and the FIFO flags overflow.
  - Next state: STOP if [10], else IDLE.
- STOP, q0..q3: SCL low, SDA low / SCL rel, SDA low / SCL rel, SDA rel / hold. Then go to IDLE.
- Between ops without STOP, SCL is held low and SDA holds its last driven value. This stalls the bus and gives op_fifo_block atomic multi-op sequences.
- op_fifo_block is sampled only in IDLE; an op in flight always completes.
- Simultaneous error and push cannot occur: RNW selects exactly one.
- busy is registered and tracks state; it is 1 from the FETCH cycle until the cycle IDLE is re-entered.

Optional Feature:
- Macro: IIC_CLOCK_STRETCH_EN.
- Defined: in BIT/ACK/START/STOP, after SCL is released, the quarter counter holds at 0 until scl_i reads 1. This supports slave clock stretching.
- Undefined: scl_i is ignored and timing is purely counter-based.

Test Plan (CLK_DIV=4, one quarter = 4 clocks):
- Op 0xC5A (START+STOP, write 0x5A), slave ACKs -> SDA bits 0,1,0,1,1,0,1,0 on SCL rising edges; op_error stays 0; busy=1 for 2+4*(4+32+4+4) clocks; lines released at end.
- Op 0x8A0 with slave leaving SDA high in ACK -> op_error pulses exactly 1 cycle; no STOP issued; SCL held low in IDLE.
- Ops 0x8A1 (START, write), then 0x700 (RNW+NACK+STOP), slave returns 0xC3 -> rx_fifo_wr_en 1 cycle with data 0xC3; master SDA released in ACK; STOP follows.
- op_fifo_block=1 with 3 ops queued -> no rd_en; deassert -> ops pop one at a time, each rd_en only after the previous returns to IDLE.
- Assert OPB_Rst_n=0 mid-BIT (idx 4) -> next cycle scl_oen=sda_oen=1, busy=0, no strobes; after release, resumes from IDLE with the next queued op.
- With IIC_CLOCK_STRETCH_EN, force scl_i=0 for 20 clocks after SCL release -> the bit period extends by 20 clocks; sampled data is unchanged.
